// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole player input judge.
package whack_pkg;

  localparam int N_HOLES           = 5;
  localparam int DB_CYCLES_DEFAULT = 1000000;
  localparam int CNT_W_DEFAULT     = 20;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SCORED,
    MISSED
  } judge_state_t;

endpackage

// File: rtl/input_debouncer.sv
// One switch channel: two-flop synchroniser, debounce counter, stable level
// and a registered rising-edge strobe delayed one cycle after stable rises.
module input_debouncer
  import whack_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES);

  logic             meta_reg;
  logic             sync_reg;
  logic             stable_d_reg;
  logic [CNT_W-1:0] count_reg;

  // The counter is allowed to reach DB_CYCLES itself, so a change is accepted
  // two synchroniser cycles plus DB_CYCLES cycles after the raw edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg     <= 1'b0;
      sync_reg     <= 1'b0;
      stable       <= 1'b0;
      stable_d_reg <= 1'b0;
      rise         <= 1'b0;
      count_reg    <= '0;
    end else begin
      meta_reg     <= raw;
      sync_reg     <= meta_reg;
      stable_d_reg <= stable;
      rise         <= stable & ~stable_d_reg;
      if (sync_reg == stable) begin
        count_reg <= '0;
      end else if (count_reg == CNT_LAST) begin
        stable    <= sync_reg;
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/whack_input_judge.sv
// Debounces the player switches and judges each press against the lit mole,
// producing at most one hit or miss strobe per mole.
module whack_input_judge
  import whack_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_HOLES-1:0] mole_in,
  input  logic               new_mole,
  input  logic [N_HOLES-1:0] switch_in,
  output logic               hit,
  output logic               miss,
  output logic               armed,
  output logic [N_HOLES-1:0] db_state
);

  logic [N_HOLES-1:0] rise;
  logic [N_HOLES-1:0] wrong_rise;
  logic [N_HOLES-1:0] right_rise;
  judge_state_t       state_reg;

  generate
    for (genvar gi = 0; gi < N_HOLES; gi++) begin : g_db
      input_debouncer #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
      ) u_db (
        .clk   (clk),
        .reset (reset),
        .raw   (switch_in[gi]),
        .stable(db_state[gi]),
        .rise  (rise[gi])
      );
    end
  endgenerate

  assign wrong_rise = rise & ~mole_in;
  assign right_rise = rise & mole_in;
  assign armed      = (state_reg == ARMED);

  // A wrong rise beats a correct one in the same cycle so mashing every
  // switch at once can never score.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      hit       <= 1'b0;
      miss      <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (!enable) begin
        state_reg <= IDLE;
      end else if (new_mole) begin
        state_reg <= (mole_in != '0) ? ARMED : IDLE;
      end else if (state_reg == ARMED) begin
        if (wrong_rise != '0) begin
          miss      <= 1'b1;
          state_reg <= MISSED;
        end else if (right_rise != '0) begin
          hit       <= 1'b1;
          state_reg <= SCORED;
        end
      end
    end
  end

endmodule

// File: tb/tb_whack_input_judge.sv
// Self-checking bench: hand-built scenarios, a cycle table, and random
// stimulus compared every cycle against a behavioural model.
module tb_whack_input_judge;

  localparam int N  = 5;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] mole_in;
  logic         new_mole;
  logic [N-1:0] switch_in;
  logic         hit;
  logic         miss;
  logic         armed;
  logic [N-1:0] db_state;

  int errors = 0;
  int checks = 0;

  whack_input_judge #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mole_in  (mole_in),
    .new_mole (new_mole),
    .switch_in(switch_in),
    .hit      (hit),
    .miss     (miss),
    .armed    (armed),
    .db_state (db_state)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw input seen two cycles late, accepted once it has
  // disagreed with the accepted level for DB+1 samples in a row.
  logic [N-1:0] m_seen1, m_seen2, m_level, m_level_prev, m_rise;
  int           m_run [N];
  bit           m_open, m_hit, m_miss;

  task automatic model_step();
    logic [N-1:0] wrong, right;
    if (reset) begin
      m_seen1 = '0; m_seen2 = '0; m_level = '0; m_level_prev = '0; m_rise = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_open = 0; m_hit = 0; m_miss = 0;
      return;
    end
    wrong  = m_rise & ~mole_in;
    right  = m_rise & mole_in;
    m_hit  = enable && !new_mole && m_open && wrong == 0 && right != 0;
    m_miss = enable && !new_mole && m_open && wrong != 0;
    if (!enable) m_open = 0;
    else if (new_mole) m_open = (mole_in != 0);
    else if (m_hit || m_miss) m_open = 0;
    m_rise       = m_level & ~m_level_prev;
    m_level_prev = m_level;
    for (int i = 0; i < N; i++) begin
      if (m_seen2[i] == m_level[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DB + 1) begin
          m_level[i] = m_seen2[i];
          m_run[i]   = 0;
        end
      end
    end
    m_seen2 = m_seen1;
    m_seen1 = switch_in;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_hit", {31'd0, hit}, {31'd0, m_hit});
    chk("model_miss", {31'd0, miss}, {31'd0, m_miss});
    chk("model_armed", {31'd0, armed}, {31'd0, m_open});
    chk("model_db", {27'd0, db_state}, {27'd0, m_level});
    chk("hit_miss_excl", {31'd0, hit & miss}, 32'd0);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic quiet(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      tick();
      chk({name, "_hit"}, {31'd0, hit}, 32'd0);
      chk({name, "_miss"}, {31'd0, miss}, 32'd0);
    end
  endtask

  task automatic arm(input logic [N-1:0] m);
    new_mole = 1'b1;
    mole_in  = m;
    tick();
    new_mole = 1'b0;
  endtask

  typedef struct {
    logic         en;
    logic         nm;
    logic [N-1:0] mole;
    logic [N-1:0] sw;
    logic         e_hit;
    logic         e_miss;
    logic [1:0]   e_armed;  // 2 = not checked
    logic [N-1:0] e_db;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int n_hit, n_miss;
    bit saw_db, saw_hit;

    // Correct press on mole 2: edge 0 press, stable at 6, hit at edge 8.
    tbl[0]  = '{1'b1, 1'b1, 5'b00100, 5'b00000, 1'b0, 1'b0, 2'd1, 5'b00000};
    tbl[1]  = '{1'b1, 1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0, 2'd1, 5'b00000};
    tbl[2]  = '{1'b1, 1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0, 2'd1, 5'b00000};
    tbl[3]  = '{1'b1, 1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0, 2'd1, 5'b00000};
    tbl[4]  = '{1'b1, 1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0, 2'd1, 5'b00000};
    tbl[5]  = '{1'b1, 1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0, 2'd1, 5'b00000};
    tbl[6]  = '{1'b1, 1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0, 2'd1, 5'b00000};
    tbl[7]  = '{1'b1, 1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0, 2'd1, 5'b00100};
    tbl[8]  = '{1'b1, 1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0, 2'd1, 5'b00100};
    tbl[9]  = '{1'b1, 1'b0, 5'b00100, 5'b00100, 1'b1, 1'b0, 2'd2, 5'b00100};
    tbl[10] = '{1'b1, 1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0, 2'd0, 5'b00100};

    reset = 1'b1; enable = 1'b0; new_mole = 1'b0; mole_in = '0; switch_in = 5'b11111;

    // Scenario 1: reset with switches held, then debounce after release.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_hit", {31'd0, hit}, 32'd0);
      chk("rst_miss", {31'd0, miss}, 32'd0);
      chk("rst_armed", {31'd0, armed}, 32'd0);
      chk("rst_db", {27'd0, db_state}, 32'd0);
    end
    reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      chk("s1_db", {27'd0, db_state}, (e < 6) ? 32'd0 : 32'h1F);
    end
    quiet(2, "s1");
    switch_in = '0;
    run(10);
    $display("scenario 1 done errors=%0d", errors);

    // Scenario 2: table-driven correct press, then a second press ignored.
    for (int k = 0; k < 11; k++) begin
      enable = tbl[k].en; new_mole = tbl[k].nm; mole_in = tbl[k].mole; switch_in = tbl[k].sw;
      tick();
      $display("vec %0d sw=%b hit=%b miss=%b armed=%b db=%b", k, switch_in, hit, miss, armed, db_state);
      chk("s2_hit", {31'd0, hit}, {31'd0, tbl[k].e_hit});
      chk("s2_miss", {31'd0, miss}, {31'd0, tbl[k].e_miss});
      if (tbl[k].e_armed != 2'd2) chk("s2_armed", {31'd0, armed}, {31'd0, tbl[k].e_armed[0]});
      chk("s2_db", {27'd0, db_state}, {27'd0, tbl[k].e_db});
    end
    new_mole = 1'b0;
    switch_in = '0;
    quiet(8, "s2_release");
    switch_in = 5'b00100;
    quiet(10, "s2_repress");
    chk("s2_armed_after", {31'd0, armed}, 32'd0);

    // Scenario 3: wrong press gives a single miss; later correct press ignored.
    switch_in = '0;
    run(10);
    arm(5'b00010);
    chk("s3_armed", {31'd0, armed}, 32'd1);
    switch_in = 5'b10000;
    for (int e = 0; e <= 9; e++) begin
      tick();
      chk("s3_miss", {31'd0, miss}, (e == 8) ? 32'd1 : 32'd0);
      chk("s3_hit", {31'd0, hit}, 32'd0);
    end
    chk("s3_armed_after", {31'd0, armed}, 32'd0);
    switch_in = '0;
    quiet(10, "s3_release");
    switch_in = 5'b00010;
    quiet(10, "s3_late");
    $display("scenario 3 done errors=%0d", errors);

    // Scenario 4: 3-cycle glitch rejected, 6-cycle pulse accepted.
    switch_in = '0;
    run(10);
    arm(5'b00001);
    for (int e = 0; e <= 12; e++) begin
      switch_in = (e < 3) ? 5'b00001 : 5'b00000;
      tick();
      chk("s4_glitch_db", {31'd0, db_state[0]}, 32'd0);
      chk("s4_glitch_hit", {31'd0, hit | miss}, 32'd0);
    end
    saw_db = 0; saw_hit = 0;
    for (int e = 0; e <= 14; e++) begin
      switch_in = (e < 6) ? 5'b00001 : 5'b00000;
      tick();
      if (db_state[0]) saw_db = 1;
      if (hit) saw_hit = 1;
    end
    chk("s4_pulse_db", {31'd0, saw_db}, 32'd1);
    chk("s4_pulse_hit", {31'd0, saw_hit}, 32'd1);
    $display("scenario 4 done errors=%0d", errors);

    // Scenario 5a: correct and wrong rise together count as one miss.
    run(10);
    arm(5'b00001);
    switch_in = 5'b01001;
    n_hit = 0; n_miss = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_hit += int'(hit);
      n_miss += int'(miss);
    end
    chk("s5_miss_count", n_miss, 32'd1);
    chk("s5_hit_count", n_hit, 32'd0);
    switch_in = '0;
    run(10);

    // Scenario 5b: new_mole in the same cycle the rise reaches the judge.
    arm(5'b00001);
    switch_in = 5'b00001;
    quiet(8, "s5b_pre");
    new_mole = 1'b1;
    tick();
    new_mole = 1'b0;
    chk("s5b_hit", {31'd0, hit}, 32'd0);
    chk("s5b_miss", {31'd0, miss}, 32'd0);
    chk("s5b_armed", {31'd0, armed}, 32'd1);
    quiet(6, "s5b_held");
    chk("s5b_armed_held", {31'd0, armed}, 32'd1);
    $display("scenario 5 done errors=%0d", errors);

    // Scenario 6: disabling while armed discards presses; re-arm afterwards.
    switch_in = '0;
    run(10);
    arm(5'b00100);
    chk("s6_armed", {31'd0, armed}, 32'd1);
    enable = 1'b0;
    tick();
    chk("s6_disarmed", {31'd0, armed}, 32'd0);
    switch_in = 5'b00100;
    quiet(12, "s6_disabled");
    chk("s6_idle", {31'd0, armed}, 32'd0);
    enable = 1'b1;
    arm(5'b00010);
    chk("s6_rearmed", {31'd0, armed}, 32'd1);
    $display("scenario 6 done errors=%0d", errors);

    // Random stimulus against the model, including occasional resets.
    for (int k = 0; k < 800; k++) begin
      reset    = ($urandom_range(0, 199) == 0);
      enable   = ($urandom_range(0, 19) != 0);
      new_mole = ($urandom_range(0, 11) == 0);
      if (new_mole) begin
        int r;
        r = $urandom_range(0, 5);
        mole_in = (r == 5) ? 5'b00000 : 5'(1 << r);
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) switch_in[i] = ~switch_in[i];
      tick();
    end
    $display("random phase done errors=%0d", errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
